// File: rtl/audio_decim_deemph.sv
// Boxcar decimator by 2^LOG2_DECIM feeding a single-entry valid/ready output register.
// Define AUDIO_DEEMPH_EN to include the first-order IIR de-emphasis filter ahead of the output.
module audio_decim_deemph #(
  parameter int LOG2_DECIM  = 3,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] data_i,
  input  logic               valid_i,
  output logic signed [15:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               overflow_o
);

  localparam int AW = 16 + LOG2_DECIM;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  if (LOG2_DECIM < 1 || LOG2_DECIM > 6) begin : g_bad_decim
    $error("audio_decim_deemph: LOG2_DECIM must be 1..6");
  end
  if (ALPHA_SHIFT < 1 || ALPHA_SHIFT > 8) begin : g_bad_alpha
    $error("audio_decim_deemph: ALPHA_SHIFT must be 1..8");
  end

  logic signed [15:0]    in_data_q;
  logic                  in_vld_q;
  logic signed [AW-1:0]  acc_q, acc_d, sum;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic signed [15:0]    dec_q, dec_d;
  logic                  dec_vld_q, dec_vld_d;
  logic signed [15:0]    y_next;
  logic [0:0]            state_q, state_d;
  logic signed [15:0]    data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  load, drop;

  // Capture register: the sample accepted at edge t is accumulated at t+1,
  // giving dec_vld after t+1 and valid_o after t+2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_vld_q  <= 1'b0;
      in_data_q <= '0;
    end else begin
      in_vld_q  <= valid_i;
      in_data_q <= data_i;
    end
  end

  always_comb begin
    sum       = acc_q + {{LOG2_DECIM{in_data_q[15]}}, in_data_q};
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    dec_vld_d = 1'b0;
    if (in_vld_q) begin
      if (cnt_q == '1) begin
        // Slicing above the shift amount is the floor (arithmetic) shift.
        dec_d     = sum[LOG2_DECIM +: 16];
        acc_d     = '0;
        cnt_d     = '0;
        dec_vld_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      dec_q     <= '0;
      dec_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      dec_vld_q <= dec_vld_d;
    end
  end

  always_comb begin
    load    = dec_vld_q && ((state_q == ST_EMPTY) || ready_i);
    drop    = dec_vld_q && (state_q == ST_FULL) && !ready_i;
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q | drop;
    if (load) begin
      state_d = ST_FULL;
      data_d  = y_next;
    end else if ((state_q == ST_FULL) && ready_i) begin
      state_d = ST_EMPTY;
    end
  end

`ifdef AUDIO_DEEMPH_EN
  logic signed [15:0] y_q;
  logic signed [16:0] diff;
  logic signed [15:0] step;

  // y moves a 2^-ALPHA_SHIFT fraction toward dec; only committed when the sample is kept.
  always_comb begin
    diff   = {dec_q[15], dec_q} - {y_q[15], y_q};
    step   = 16'(diff >>> ALPHA_SHIFT);
    y_next = y_q + step;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_q <= '0;
    end else if (load) begin
      y_q <= y_next;
    end
  end
`else
  always_comb begin
    y_next = dec_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = (state_q == ST_FULL);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_audio_decim_deemph.sv
// Directed bench for audio_decim_deemph (LOG2_DECIM=3, ALPHA_SHIFT=3) against a block-mean
// reference model; honours AUDIO_DEEMPH_EN the same way the design does.
module tb_audio_decim_deemph;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               valid_i = 1'b0;
  logic               ready_i = 1'b0;
  logic signed [15:0] data_i = '0;
  logic signed [15:0] data_o;
  logic               valid_o;
  logic               overflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_decim_deemph #(
    .LOG2_DECIM (3),
    .ALPHA_SHIFT(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overflow_o(overflow_o)
  );

  function automatic int floordiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int filt(int y, int d);
`ifdef AUDIO_DEEMPH_EN
    return y + floordiv(d - y, 8);
`else
    return d;
`endif
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: block means are queued with the edge at which they reach the output register.
  int ecnt = 0;
  int blk_sum = 0;
  int blk_n = 0;
  int pdue[$];
  int pval[$];
  int m_y = 0;
  int m_data = 0;
  bit m_valid = 1'b0;
  bit m_ovf = 1'b0;
  bit chk_en = 1'b0;
  int xfers[$];

  always @(posedge clk) begin
    int v;
    ecnt++;
    if (!rst) begin
      blk_sum = 0; blk_n = 0; m_y = 0; m_data = 0; m_valid = 0; m_ovf = 0;
      pdue.delete(); pval.delete();
      chk_en = 1'b1;
    end else begin
      if (pdue.size() > 0 && pdue[0] == ecnt) begin
        v = pval.pop_front();
        void'(pdue.pop_front());
        if (!m_valid || ready_i) begin
          m_y = filt(m_y, v);
          m_data = m_y;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && ready_i) begin
        m_valid = 1'b0;
      end
      if (valid_i) begin
        blk_sum += int'(data_i);
        blk_n++;
        if (blk_n == 8) begin
          pdue.push_back(ecnt + 2);
          pval.push_back(floordiv(blk_sum, 8));
          blk_sum = 0;
          blk_n = 0;
        end
      end
    end
  end

  // Sink log: a transfer happens at the coming edge.
  always @(negedge clk) begin
    if (chk_en && rst && valid_o && ready_i) xfers.push_back(int'(data_o));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_o", int'(valid_o), int'(m_valid));
      if (m_valid) chk("data_o", int'(data_o), m_data);
      chk("overflow_o", int'(overflow_o), int'(m_ovf));
    end
  end

  function automatic int xf(int i);
    if (i < xfers.size()) return xfers[i];
    return 99999;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic send(int v);
    valid_i = 1'b1;
    data_i  = 16'(v);
    cyc();
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    xfers.delete();
  endtask

  int e1[3];
  int e2, e3a, e3b, e4, e5;

  initial begin
`ifdef AUDIO_DEEMPH_EN
    e1[0] = 125; e1[1] = 234; e1[2] = 329;
    e2 = -1; e3a = 4095; e3b = -513; e4 = 12; e5 = 37;
`else
    e1[0] = 1000; e1[1] = 1000; e1[2] = 1000;
    e2 = -5; e3a = 32767; e3b = -32768; e4 = 100; e5 = 300;
`endif
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_data", int'(data_o), 0);

    // Constant input, sink always ready; latency of two edges after the 8th sample
    ready_i = 1'b1;
    repeat (8) send(1000);
    @(negedge clk); chk("lat_capture", int'(valid_o), 0);
    cyc(); @(negedge clk); chk("lat_dec", int'(valid_o), 0);
    cyc(); @(negedge clk); chk("lat_out", int'(valid_o), 1);
    chk("s1_first", int'(data_o), e1[0]);
    repeat (16) send(1000);
    idle(6);
    chk("s1_count", xfers.size(), 3);
    for (int i = 0; i < 3; i++) chk("s1_out", xf(i), e1[i]);

    // Floor rounding of a negative mean
    do_reset();
    for (int v = -8; v <= -1; v++) send(v);
    idle(4);
    chk("s2_floor", xf(0), e2);

    // Full-scale extremes, no wrap
    do_reset();
    repeat (8) send(32767);
    repeat (8) send(-32768);
    idle(4);
    chk("s3_max", xf(0), e3a);
    chk("s3_min", xf(1), e3b);
    chk("s3_ovf", int'(overflow_o), 0);

    // Stalled sink: second block dropped, overflow sticky, drain gives first only
    do_reset();
    ready_i = 1'b0;
    repeat (8) send(100);
    repeat (8) send(200);
    @(negedge clk); chk("s4_ovf_e0", int'(overflow_o), 0);
    cyc(); @(negedge clk); chk("s4_ovf_e1", int'(overflow_o), 0);
    cyc(); @(negedge clk); chk("s4_ovf_e2", int'(overflow_o), 1);
    chk("s4_hold", int'(data_o), e4);
    idle(3);
    chk("s4_hold_late", int'(data_o), e4);
    ready_i = 1'b1;
    idle(3);
    chk("s4_drain_cnt", xfers.size(), 1);
    chk("s4_drain_val", xf(0), e4);
    chk("s4_empty", int'(valid_o), 0);
    chk("s4_sticky", int'(overflow_o), 1);

    // Mid-block reset discards the partial block
    do_reset();
    repeat (5) send(500);
    rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("s5_valid", int'(valid_o), 0);
    chk("s5_data", int'(data_o), 0);
    chk("s5_ovf", int'(overflow_o), 0);
    rst = 1'b1;
    xfers.delete();
    repeat (7) send(300);
    idle(4);
    chk("s5_none_yet", xfers.size() + int'(valid_o), 0);
    send(300);
    idle(3);
    chk("s5_first", xf(0), e5);

    // Gapped input, sink ready only on the cycle a new sample arrives
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 52; i++) begin
      valid_i = (i < 48) && (i % 2 == 0);
      data_i  = 16'sd1000;
      ready_i = (pdue.size() > 0 && pdue[0] == ecnt + 1);
      cyc();
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    idle(2);
    chk("s6_count", xfers.size(), 2);
    chk("s6_out0", xf(0), e1[0]);
    chk("s6_out1", xf(1), e1[1]);
    chk("s6_held", int'(data_o), e1[2]);
    chk("s6_ovf", int'(overflow_o), 0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_decim_deemph.md
# audio_decim_deemph

Audio post-processing stage directly downstream of the FM demodulator `top`. It consumes the 16-bit signed demodulated stream (`data_o`/`valid_o` of the demodulator) and reduces its rate by DECIM using a boxcar accumulate-and-dump decimator. An optional first-order IIR de-emphasis filter follows. Results go to a single-entry output register with a valid/ready handshake for the audio sink or file writer.

## Interface
- `LOG2_DECIM`, default 3: decimation factor is DECIM = 2^LOG2_DECIM. Legal range is 1..6.
- `ALPHA_SHIFT`, default 3: de-emphasis coefficient. alpha = 2^-ALPHA_SHIFT. Legal range is 1..8.
- `clk`  in  1: clock. All logic is rising-edge.
- `rst`  in  1: reset, synchronous, active-low.
- `data_i`  in  16: signed demodulator sample.
- `valid_i`  in  1: `data_i` is accepted on every rising edge where `valid_i`=1. There is no backpressure upstream.
- `data_o`  out  16: signed decimated (and optionally de-emphasised) audio sample.
- `valid_o`  out  1: `data_o` holds a sample.
- `ready_i`  in  1: sink accepts `data_o` when `valid_o`=1 and `ready_i`=1.
- `overflow_o`  out  1: sticky flag. Set when a decimated sample is dropped. Cleared only by reset.

## Operation
- **Accumulator stage**
  - Signed accumulator, 16+LOG2_DECIM bits wide. Sample counter `cnt` runs 0..DECIM-1.
  - On an accepted sample with `cnt`<DECIM-1: acc += `data_i`, `cnt`++.
  - On an accepted sample with `cnt`=DECIM-1: `dec` <= (acc+`data_i`) >>> LOG2_DECIM, which is an arithmetic shift (floor). In the same edge: acc <= 0, `cnt` <= 0, `dec_vld` <= 1. Otherwise `dec_vld` <= 0.
  - The accumulator width makes overflow impossible. The result always fits in 16 bits, so no saturation is needed.
- **Filter stage**, active in the cycle where `dec_vld`=1:
  - With the filter compiled in: `y_next` = y + ((`dec` − y) >>> ALPHA_SHIFT). The difference is computed at 17 bits. `y_next` is a convex combination of y and `dec`, so it always fits in 16 bits.
  - With the filter compiled out: `y_next` = `dec`.
- **Output register**, two states:
  - EMPTY (`valid_o`=0):
    - On `dec_vld`: load `data_o` <= `y_next`, update y <= `y_next`, and go to FULL.
  - FULL (`valid_o`=1): `data_o` stays stable until a transfer.
    - `ready_i`=1 and `dec_vld`=1: load the new `y_next` and stay FULL. This is a back-to-back transfer with no drop.
    - `ready_i`=1 and `dec_vld`=0: go to EMPTY.
    - `ready_i`=0 and `dec_vld`=1: drop the new sample, leave y unchanged, set `overflow_o`=1.
- The accumulator keeps running regardless of output state. Upstream is never stalled.
- **Reset:** synchronous and active-low, applied at any time, including mid-block. It clears acc, `cnt`, `dec`, `dec_vld`, y, `data_o`=0, `valid_o`=0 and `overflow_o`=0. The partial block is discarded, and the next output needs DECIM fresh accepted samples.

## Timing
- **Latency:** the DECIM-th sample is accepted at edge t. `dec_vld` is high after edge t+1 (the filter cycle). `valid_o` is high after edge t+2 when the output register is EMPTY or draining.
- Latency is identical with and without the de-emphasis filter.
- **Throughput:** at most one output per DECIM accepted inputs. A sink holding `ready_i`=1 never causes a drop.
- **Gaps:** gaps in `valid_i` stall only `cnt` and acc, with no other effect.

## Configuration
- `AUDIO_DEEMPH_EN` defined: the IIR de-emphasis filter and the y state register are compiled in.
- `AUDIO_DEEMPH_EN` undefined: the filter logic is removed and `data_o` carries the raw decimated value. Latency, handshake and overflow behaviour are unchanged.

## Test plan
All scenarios use LOG2_DECIM=3 and ALPHA_SHIFT=3.
1. Constant 1000, `valid_i`=1, `ready_i`=1:
   - Filter off: first `valid_o` 2 edges after the 8th sample, `data_o`=1000 on every output.
   - Filter on: outputs are 125, 234, 329, ...
2. Inputs −8..−1, filter off → `data_o` = −36 >>> 3 = −5 (floor, not −4).
3. Inputs all 32767, then all −32768, filter off → outputs exactly 32767 and −32768, with no wrap.
4. Hold `ready_i`=0 across 16 inputs:
   - The first output holds stable.
   - The second decimated sample is dropped and `overflow_o` rises 2 edges after input 16 and stays high.
   - `ready_i`=1 then drains the first value only.
5. Assert `rst`=0 for one edge after 5 accepted samples:
   - All outputs read 0 after that edge.
   - The next `valid_o` needs 8 new samples.
6. `valid_i` toggling 1/0 with `ready_i` pulsing on the same edge as `dec_vld` while FULL → back-to-back transfer, no overflow, results identical to scenario 1.
